// File: rtl/cnt4_pkg.sv
// Shared constants for the 4-bit counter sequencer: state encoding,
// direction codes and default widths.
package cnt4_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int STEPW_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_FIN  = 2'b10;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/cnt4_updn.sv
// WIDTH-bit up/down counter register with load and enable; reports when
// the enabled step carries or borrows out of the register.
module cnt4_updn
  import cnt4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] q_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   inc_w, dec_w;

  // One extra bit holds the carry/borrow; it is used for nothing but the wrap flag.
  assign inc_w = {1'b0, q_q} + (WIDTH+1)'(1);
  assign dec_w = {1'b0, q_q} - (WIDTH+1)'(1);

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      q_d = (dir_i == DIR_DN) ? dec_w[WIDTH-1:0] : inc_w[WIDTH-1:0];
    end
  end

  assign wrap_o = en_i && !load_i && ((dir_i == DIR_DN) ? dec_w[WIDTH] : inc_w[WIDTH]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/cnt4_seq.sv
// Sequencer for the 4-bit counter datapath: load a start value, step it
// up or down a programmed number of times, with pause, abort and status.
module cnt4_seq
  import cnt4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEPW = STEPW_DEF
) (
  input  logic             B,
  input  logic             C,
  input  logic             START,
  input  logic             DIR,
  input  logic [WIDTH-1:0] INIT,
  input  logic [STEPW-1:0] STEPS,
  input  logic             HOLD,
  input  logic             ABORT,
  output logic [WIDTH-1:0] Q,
  output logic [STEPW-1:0] REMAIN,
  output logic             BUSY,
  output logic             DONE,
  output logic             WRAP
);

  logic [1:0]       state_q, state_d;
  logic             dir_q, dir_d;
  logic [STEPW-1:0] remain_q, remain_d;
  logic             busy_q, done_q, wrap_q;
  logic             load_w, en_w, wrap_w;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    remain_d = remain_q;
    load_w   = 1'b0;
    en_w     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START && !ABORT) begin
          load_w   = 1'b1;
          dir_d    = DIR;
          remain_d = STEPS;
          state_d  = (STEPS == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (ABORT) begin
          remain_d = '0;
          state_d  = ST_IDLE;
        end else if (!HOLD) begin
          en_w     = 1'b1;
          remain_d = remain_q - STEPW'(1);
          if (remain_q == STEPW'(1)) begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        remain_d = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  cnt4_updn #(
    .WIDTH(WIDTH)
  ) u_updn (
    .clk_i     (B),
    .rst_i     (C),
    .load_i    (load_w),
    .load_val_i(INIT),
    .en_i      (en_w),
    .dir_i     (dir_q),
    .q_o       (Q),
    .wrap_o    (wrap_w)
  );

  // Status flags are derived from the next state so they line up with it.
  always_ff @(posedge B or posedge C) begin
    if (C) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_UP;
      remain_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      remain_q <= remain_d;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_FIN);
      wrap_q   <= wrap_w;
    end
  end

  assign REMAIN = remain_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign WRAP   = wrap_q;

endmodule
